// File: rtl/subneg_loader_if.sv
// subneg_loader_if: byte-stream input, program-memory write port and CPU control for the loader
interface subneg_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              reload;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;
    modport master (
        output in_valid, in_data, reload,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err
    );
    modport slave (
        input  in_valid, in_data, reload,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err
    );
endinterface

// File: rtl/subneg_loader.sv
// subneg_loader: fills SUBNEG program memory from a little-endian byte stream, then releases the CPU
module subneg_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input logic             clk,
    input logic             rst,
    subneg_loader_if.slave  ld
);
    localparam int BPW = DATA_W / 8;
    localparam int IDX_W = BPW > 1 ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(BPW - 1);
    localparam int unsigned MAX_N = (ADDR_W >= 16) ? 32'h10000 : (32'd1 << ADDR_W);
    typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, WRITE, DONE, ERR} state_t;
    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [15:0]       n_q;
    logic [DATA_W-1:0] word_q;
    logic              xfer;
    logic [15:0]       n_hdr;
    assign xfer  = ld.in_valid && ld.in_ready;
    assign n_hdr = {ld.in_data, n_q[7:0]};
    // n_q counts down the words still to write once the header is in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HDR_LO;
            addr_q  <= '0;
            idx_q   <= '0;
            n_q     <= '0;
            word_q  <= '0;
        end else begin
            case (state_q)
                HDR_LO: if (xfer) begin
                    n_q[7:0] <= ld.in_data;
                    state_q  <= HDR_HI;
                end
                HDR_HI: if (xfer) begin
                    n_q     <= n_hdr;
                    addr_q  <= '0;
                    idx_q   <= '0;
                    state_q <= n_hdr == 16'd0 ? DONE : 32'(n_hdr) > MAX_N ? ERR : DATA;
                end
                DATA: if (xfer) begin
                    word_q[{idx_q, 3'b000} +: 8] <= ld.in_data;
                    idx_q   <= idx_q == LAST ? '0 : idx_q + 1'b1;
                    state_q <= idx_q == LAST ? WRITE : DATA;
                end
                WRITE: begin
                    addr_q  <= addr_q + 1'b1;
                    n_q     <= n_q - 16'd1;
                    state_q <= n_q == 16'd1 ? DONE : DATA;
                end
                DONE: if (ld.reload) begin
                    addr_q  <= '0;
                    idx_q   <= '0;
                    state_q <= HDR_LO;
                end
                default: ;
            endcase
        end
    end
    assign ld.in_ready  = state_q == HDR_LO || state_q == HDR_HI || state_q == DATA;
    assign ld.mem_we    = state_q == WRITE;
    assign ld.mem_addr  = addr_q;
    assign ld.mem_wdata = word_q;
    assign ld.cpu_rst   = state_q != DONE;
    assign ld.done      = state_q == DONE;
    assign ld.err       = state_q == ERR;
    assign ld.busy      = state_q == HDR_HI || state_q == DATA || state_q == WRITE;
endmodule

// File: tb/tb_subneg_loader.sv
// tb_subneg_loader: directed-vector bench for subneg_loader (DATA_W=16, ADDR_W=8)
module tb_subneg_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    logic [7:0]  wa[$];
    logic [15:0] wd[$];
    int          wc[$];
    always #5 clk = ~clk;
    subneg_loader_if #(.DATA_W(16), .ADDR_W(8)) bus();
    subneg_loader #(.DATA_W(16), .ADDR_W(8)) dut (.clk(clk), .rst(rst), .ld(bus));
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wdata);
            wc.push_back(cyc);
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] b);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && t < 100) begin
            tick(1);
            t++;
        end
        if (t == 100) chk("send_timeout", bus.in_ready, 1);
        tick(1);
    endtask
    task automatic clearq();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask
    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.reload   = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        clearq();
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [23:0] exp_nl[3];
        logic [23:0] exp_bp[4];
        logic [7:0]  bp[8];
        exp_nl = '{24'h001234, 24'h015678, 24'h029ABC};
        exp_bp = '{24'h00B2A1, 24'h01D4C3, 24'h02F6E5, 24'h031807};
        bp     = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.reload   = 1'b0;
        do_reset();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_cpu_rst", bus.cpu_rst, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        // normal load, with a byte held valid across the first WRITE
        send(8'h03);
        chk("nl_busy_hdr", bus.busy, 1);
        send(8'h00);
        send(8'h34);
        send(8'h12);
        bus.in_data = 8'h78;
        @(negedge clk);
        chk("nl_stall_ready", bus.in_ready, 0);
        chk("nl_stall_we", bus.mem_we, 1);
        send(8'h78);
        send(8'h56);
        send(8'hBC);
        send(8'h9A);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("nl_last_we", bus.mem_we, 1);
        chk("nl_last_word", {bus.mem_addr, bus.mem_wdata}, 24'h029ABC);
        @(negedge clk);
        chk("nl_done", bus.done, 1);
        chk("nl_cpu_rst", bus.cpu_rst, 0);
        chk("nl_we_off", bus.mem_we, 0);
        chk("nl_nwrites", wa.size(), 3);
        for (int i = 0; i < 3 && i < wa.size(); i++) chk("nl_write", {wa[i], wd[i]}, exp_nl[i]);
        if (wc.size() == 3) begin
            chk("nl_gap1", wc[1] - wc[0], 3);
            chk("nl_gap2", wc[2] - wc[1], 3);
        end
        // reload from DONE, then a reload pulse in DATA must be ignored
        tick(1);
        bus.reload = 1'b1;
        tick(1);
        bus.reload = 1'b0;
        chk("rl_cpu_rst", bus.cpu_rst, 1);
        chk("rl_done", bus.done, 0);
        chk("rl_in_ready", bus.in_ready, 1);
        chk("rl_busy", bus.busy, 0);
        clearq();
        send(8'h02);
        send(8'h00);
        send(8'h11);
        bus.in_valid = 1'b0;
        bus.reload = 1'b1;
        tick(1);
        bus.reload = 1'b0;
        chk("rl_data_busy", bus.busy, 1);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        bus.in_valid = 1'b0;
        tick(3);
        chk("rl_nwrites", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("rl_w0", {wa[0], wd[0]}, 24'h002211);
            chk("rl_w1", {wa[1], wd[1]}, 24'h014433);
        end
        chk("rl_done2", bus.done, 1);
        // empty image
        do_reset();
        send(8'h00);
        send(8'h00);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("em_done", bus.done, 1);
        chk("em_cpu_rst", bus.cpu_rst, 0);
        chk("em_busy", bus.busy, 0);
        tick(3);
        chk("em_nwrites", wa.size(), 0);
        // oversize header N=257
        do_reset();
        send(8'h01);
        send(8'h01);
        bus.in_data = 8'h55;
        bus.in_valid = 1'b1;
        tick(5);
        chk("ov_err", bus.err, 1);
        chk("ov_in_ready", bus.in_ready, 0);
        chk("ov_busy", bus.busy, 0);
        chk("ov_cpu_rst", bus.cpu_rst, 1);
        bus.in_valid = 1'b0;
        bus.reload = 1'b1;
        tick(1);
        bus.reload = 1'b0;
        chk("ov_err_sticky", bus.err, 1);
        chk("ov_nwrites", wa.size(), 0);
        // maximum image N=256
        do_reset();
        send(8'h00);
        send(8'h01);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            send(b);
            send(~b);
        end
        bus.in_valid = 1'b0;
        tick(3);
        chk("mx_nwrites", wa.size(), 256);
        for (int i = 0; i < 256 && i < wa.size(); i++) begin
            logic [7:0] b;
            b = 8'(i);
            chk("mx_write", {wa[i], wd[i]}, {b, ~b, b});
        end
        chk("mx_done", bus.done, 1);
        chk("mx_addr_wrap", bus.mem_addr, 0);
        // back-pressure with random gaps in in_valid
        do_reset();
        send(8'h04);
        send(8'h00);
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                bus.in_valid = 1'b0;
                tick($urandom_range(1, 3));
            end
            send(bp[i]);
        end
        bus.in_valid = 1'b0;
        tick(3);
        chk("bp_nwrites", wa.size(), 4);
        for (int i = 0; i < 4 && i < wa.size(); i++) chk("bp_write", {wa[i], wd[i]}, exp_bp[i]);
        chk("bp_done", bus.done, 1);
        // asynchronous reset in the middle of the third word
        do_reset();
        send(8'h05);
        send(8'h00);
        for (int i = 1; i <= 5; i++) send(8'(i));
        bus.in_valid = 1'b0;
        tick(2);
        chk("mr_pre_writes", wa.size(), 2);
        #2 rst = 1'b1;
        #1;
        chk("mr_cpu_rst", bus.cpu_rst, 1);
        chk("mr_in_ready", bus.in_ready, 1);
        chk("mr_busy", bus.busy, 0);
        tick(1);
        rst = 1'b0;
        clearq();
        send(8'h01);
        send(8'h00);
        send(8'hEF);
        send(8'hBE);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mr_we", bus.mem_we, 1);
        @(negedge clk);
        chk("mr_done", bus.done, 1);
        chk("mr_nwrites", wa.size(), 1);
        if (wa.size() == 1) chk("mr_write", {wa[0], wd[0]}, 24'h00BEEF);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/subneg_loader.md
Name: subneg_loader

Overview:
- Program loader at the far end of the SUBNEG memory interface. The CPU control sequencer reads and writes program memory; this block fills that memory before the CPU runs.
- Accepts a byte stream over a valid/ready handshake and assembles bytes into DATA_W-bit words, little-endian.
- Writes the words to program memory from address 0 upward.
- Holds the CPU in reset (cpu_rst) until the image is complete, then releases it.

Parameters:
- DATA_W, 16, memory word width in bits; must be a multiple of 8.
- ADDR_W, 8, program memory address width in bits.
- BPW, DATA_W/8, bytes per word (derived localparam, not overridable).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- reload  input  1  single-cycle request to start a new load; honoured only in DONE.
- mem_we  output  1  program memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  DATA_W  write data.
- cpu_rst  output  1  high = hold the SUBNEG CPU in reset.
- busy  output  1  load in progress.
- done  output  1  image loaded, CPU released.
- err  output  1  header rejected.

Behaviour:
- A byte is transferred on a rising clk edge when in_valid && in_ready. Nothing else consumes a byte.
- Stream format:
  - 2-byte header: word count N, low byte first, 16 bits.
  - Then N*BPW data bytes. Byte k of a word lands in bits [8k+7:8k].
- States: HDR_LO, HDR_HI, DATA, WRITE, DONE, ERR.
- Transitions:
  - HDR_LO -> HDR_HI on transfer; the byte is latched as N[7:0].
  - HDR_HI -> on transfer, N[15:8] is latched, then:
    - N == 0 -> DONE.
    - N > 2**ADDR_W -> ERR.
    - otherwise -> DATA, with addr=0 and byte index=0.
    - When ADDR_W >= 16, the ERR branch is never taken.
  - DATA: each transfer stores the byte at the current byte index, then increments the index. When the transfer carries byte BPW-1, the index clears and the state goes to WRITE.
  - WRITE lasts exactly one cycle. In it: mem_we=1, mem_addr=addr, mem_wdata=assembled word. Then addr increments.
    - If this was word N -> DONE.
    - Otherwise -> DATA.
  - DONE: stays until reload=1, then -> HDR_LO. reload is ignored in every other state.
  - ERR: stays until rst.
- Output decode (combinational from state):
  - in_ready=1 in HDR_LO, HDR_HI and DATA only; 0 in WRITE, DONE and ERR. A byte held valid during WRITE is accepted in the following DATA cycle.
  - mem_we=1 only in WRITE.
  - cpu_rst=0 only in DONE.
  - done=1 only in DONE.
  - err=1 only in ERR.
  - busy=1 in HDR_HI, DATA and WRITE.
- Reset values: state=HDR_LO, addr=0, byte index=0, N=0, word register=0.
  - Outputs: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, busy=0, done=0, err=0.
- mem_addr and mem_wdata show the addr and word registers in all states. They are meaningful only when mem_we=1.
- Throughput: at most one word per BPW+1 cycles. Gaps in in_valid stall the load without limit; no timeout.
- N == 2**ADDR_W is legal. After the final word, addr wraps to 0 and no further write occurs.
- Reset mid-load: the partial word is discarded, cpu_rst goes to 1 immediately (asynchronous), and the next byte is treated as a header. Memory contents already written are not cleared.
- reload in DONE: cpu_rst rises the next cycle. addr and byte index clear on entry to HDR_LO.

Test Plan:
- Normal load: stream 03 00 34 12 78 56 BC 9A, in_valid held high -> exactly three writes, (0,0x1234), (1,0x5678), (2,0x9ABC), each one cycle wide and spaced 3 cycles apart. In the cycle after the third write: done=1 and cpu_rst=0.
- Empty image: stream 00 00 -> no mem_we pulse. The cycle after the second transfer: done=1, cpu_rst=0, busy=0.
- Oversize header: stream 01 01 (N=257, ADDR_W=8) -> err=1, in_ready=0, and no writes even with more bytes offered. A separate run with 00 01 (N=256) loads 256 words, addresses 0..255.
- Back-pressure: in_valid toggled randomly, and a byte presented during a WRITE cycle -> that byte is not consumed until the next DATA cycle. Written words match the stream exactly, with no drops or duplicates.
- Reset mid-load: header N=5, rst pulsed after the second word plus one byte -> cpu_rst=1 and in_ready=1 right after reset. A new stream 01 00 EF BE writes (0,0xBEEF) and then done=1.
- Reload: assert reload in DONE -> the next cycle cpu_rst=1, done=0, state HDR_LO, and the next image writes from address 0. reload pulsed during DATA -> no effect.
